// File: rtl/mmio_io_ctrl_pkg.sv
// mmio_io_ctrl_pkg: MMIO address map, base mask and counter type shared by mmio_io_ctrl.
package mmio_io_ctrl_pkg;
  localparam logic [15:0] MMIO_BASE   = 16'hFFF0;
  localparam logic [15:0] MMIO_MASK   = 16'hFFF0;
  localparam logic [15:0] A_LEDR      = 16'hFFF0;
  localparam logic [15:0] A_HEX_LO    = 16'hFFF1;
  localparam logic [15:0] A_HEX_HI    = 16'hFFF2;
  localparam logic [15:0] A_SW        = 16'hFFF8;
  localparam logic [15:0] A_KEY       = 16'hFFF9;
  localparam logic [15:0] A_KEY_LATCH = 16'hFFFA;
  localparam logic [15:0] A_CYC_LO    = 16'hFFFB;
  localparam logic [15:0] A_CYC_HI    = 16'hFFFC;
  localparam logic [15:0] A_INS_LO    = 16'hFFFD;
  localparam logic [15:0] A_INS_HI    = 16'hFFFE;
  localparam logic [15:0] A_HALT      = 16'hFFFF;
  typedef logic [31:0] cnt_t;
  function automatic logic is_mmio(input logic [15:0] a);
    return (a & MMIO_MASK) == MMIO_BASE;
  endfunction
endpackage

// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if: processor data bus into the MMIO block (master = processor, slave = mmio_io_ctrl).
interface mmio_io_ctrl_if;
  logic [15:0] DataAddr;
  logic        WriteData;
  logic [15:0] DataWr;
  logic        ReadEn;
  logic [15:0] DataRd;
  logic        RdValid;
  modport master (output DataAddr, WriteData, DataWr, ReadEn, input DataRd, RdValid);
  modport slave (input DataAddr, WriteData, DataWr, ReadEn, output DataRd, RdValid);
endinterface

// File: rtl/hex7seg.sv
// hex7seg: hex nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: board I/O and perf counters mapped at FFF0-FFFF with 1-cycle registered reads.
// Define MMIO_PERF_CNT_EN to build the cycle/instruction counters; otherwise FFFB-FFFE read 0.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
(
  input  logic                Clock,
  input  logic                ResetN,
  mmio_io_ctrl_if.slave       bus,
  input  logic                InstrRetired,
  input  logic [9:0]          SW,
  input  logic [2:0]          KEY,
  output logic [9:0]          LEDR,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5,
  output logic                Halted
);
  logic        rd;
  logic [15:0] rdata, perf_rd;
  logic [9:0]  ledr_q, ledr_d, sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [15:0] hex_lo_q, hex_lo_d, data_rd_q, data_rd_d;
  logic [7:0]  hex_hi_q, hex_hi_d;
  logic [2:0]  key_meta_q, key_meta_d, key_sync_q, key_sync_d, key_prev_q, key_prev_d, key_latch_q, key_latch_d;
  logic        halted_q, halted_d, rd_valid_q, rd_valid_d;
  logic [23:0] nibs;
  logic [6:0]  seg [6];
  always_comb begin
    rd          = bus.ReadEn && is_mmio(bus.DataAddr);
    ledr_d      = (bus.WriteData && bus.DataAddr == A_LEDR) ? bus.DataWr[9:0] : ledr_q;
    hex_lo_d    = (bus.WriteData && bus.DataAddr == A_HEX_LO) ? bus.DataWr : hex_lo_q;
    hex_hi_d    = (bus.WriteData && bus.DataAddr == A_HEX_HI) ? bus.DataWr[7:0] : hex_hi_q;
    halted_d    = halted_q || (bus.WriteData && bus.DataAddr == A_HALT);
    sw_meta_d   = SW;
    sw_sync_d   = sw_meta_q;
    key_meta_d  = ~KEY;
    key_sync_d  = key_meta_q;
    key_prev_d  = key_sync_q;
    // a new press in the clearing cycle survives the clear
    key_latch_d = ((rd && bus.DataAddr == A_KEY_LATCH) ? 3'b000 : key_latch_q) | (key_sync_q & ~key_prev_q);
    rdata       = bus.DataAddr == A_LEDR      ? {6'b0, ledr_q}      :
                  bus.DataAddr == A_HEX_LO    ? hex_lo_q            :
                  bus.DataAddr == A_HEX_HI    ? {8'b0, hex_hi_q}    :
                  bus.DataAddr == A_SW        ? {6'b0, sw_sync_q}   :
                  bus.DataAddr == A_KEY       ? {13'b0, key_sync_q} :
                  bus.DataAddr == A_KEY_LATCH ? {13'b0, key_latch_q} : perf_rd;
    rd_valid_d  = rd;
    data_rd_d   = rd ? rdata : 16'h0000;
  end
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      ledr_q      <= '0;
      hex_lo_q    <= '0;
      hex_hi_q    <= '0;
      halted_q    <= 1'b0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      key_meta_q  <= '0;
      key_sync_q  <= '0;
      key_prev_q  <= '0;
      key_latch_q <= '0;
      rd_valid_q  <= 1'b0;
      data_rd_q   <= '0;
    end else begin
      ledr_q      <= ledr_d;
      hex_lo_q    <= hex_lo_d;
      hex_hi_q    <= hex_hi_d;
      halted_q    <= halted_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      key_prev_q  <= key_prev_d;
      key_latch_q <= key_latch_d;
      rd_valid_q  <= rd_valid_d;
      data_rd_q   <= data_rd_d;
    end
  end
`ifdef MMIO_PERF_CNT_EN
  cnt_t        cyc_q, cyc_d, ins_q, ins_d;
  logic [15:0] cyc_sh_q, cyc_sh_d, ins_sh_q, ins_sh_d;
  // low-half reads capture the high half so a later high read matches across a carry
  always_comb begin
    cyc_d    = halted_q ? cyc_q : cyc_q + 32'd1;
    ins_d    = (InstrRetired && !halted_q) ? ins_q + 32'd1 : ins_q;
    cyc_sh_d = (rd && bus.DataAddr == A_CYC_LO) ? cyc_q[31:16] : cyc_sh_q;
    ins_sh_d = (rd && bus.DataAddr == A_INS_LO) ? ins_q[31:16] : ins_sh_q;
    perf_rd  = bus.DataAddr == A_CYC_LO ? cyc_q[15:0] :
               bus.DataAddr == A_CYC_HI ? cyc_sh_q    :
               bus.DataAddr == A_INS_LO ? ins_q[15:0] :
               bus.DataAddr == A_INS_HI ? ins_sh_q    : 16'h0000;
  end
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      cyc_q    <= '0;
      ins_q    <= '0;
      cyc_sh_q <= '0;
      ins_sh_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
      cyc_sh_q <= cyc_sh_d;
      ins_sh_q <= ins_sh_d;
    end
  end
`else
  logic unused_instr;
  assign unused_instr = InstrRetired;
  assign perf_rd      = 16'h0000;
`endif
  assign nibs = {hex_hi_q, hex_lo_q};
  for (genvar i = 0; i < 6; i++) begin : g_hex
    hex7seg u_hex (.nib(nibs[4*i +: 4]), .seg(seg[i]));
  end
  assign HEX0        = seg[0];
  assign HEX1        = seg[1];
  assign HEX2        = seg[2];
  assign HEX3        = seg[3];
  assign HEX4        = seg[4];
  assign HEX5        = seg[5];
  assign LEDR        = ledr_q;
  assign Halted      = halted_q;
  assign bus.DataRd  = data_rd_q;
  assign bus.RdValid = rd_valid_q;
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed self-checking bench for mmio_io_ctrl; counter tests follow MMIO_PERF_CNT_EN.
module tb_mmio_io_ctrl;
  logic       Clock, ResetN, InstrRetired, Halted;
  logic [9:0] SW, LEDR;
  logic [2:0] KEY;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int checks = 0;
  int errors = 0;
  mmio_io_ctrl_if bus();
  mmio_io_ctrl dut (
    .Clock(Clock), .ResetN(ResetN), .bus(bus), .InstrRetired(InstrRetired),
    .SW(SW), .KEY(KEY), .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5), .Halted(Halted)
  );
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic v);
    @(negedge Clock);
    bus.DataAddr = a;
    bus.ReadEn = 1'b1;
    @(posedge Clock);
    #1;
    d = bus.DataRd;
    v = bus.RdValid;
    bus.ReadEn = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] dat);
    @(negedge Clock);
    bus.DataAddr = a;
    bus.DataWr = dat;
    bus.WriteData = 1'b1;
    @(posedge Clock);
    #1;
    bus.WriteData = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ResetN = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    ResetN = 1'b0;
    bus.DataAddr = 16'hFFF0;
    bus.ReadEn = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    checks++; if (bus.RdValid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid: got %b expected 0", bus.RdValid); end
    checks++; if (bus.DataRd !== 16'h0000) begin errors++; $display("FAIL reset_datard: got %h expected 0000", bus.DataRd); end
    checks++; if (LEDR !== 10'h000) begin errors++; $display("FAIL reset_ledr: got %h expected 000", LEDR); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", Halted); end
    checks++; if (HEX0 !== 7'h40) begin errors++; $display("FAIL reset_hex0: got %h expected 40", HEX0); end
    checks++; if (HEX5 !== 7'h40) begin errors++; $display("FAIL reset_hex5: got %h expected 40", HEX5); end
    @(negedge Clock);
    bus.ReadEn = 1'b0;
    ResetN = 1'b1;
  endtask

  task automatic test_hex();
    logic [15:0] d;
    logic v;
    wr(16'hFFF1, 16'h1234);
    checks++; if (HEX3 !== 7'h79) begin errors++; $display("FAIL hex3_glyph1: got %h expected 79", HEX3); end
    checks++; if (HEX2 !== 7'h24) begin errors++; $display("FAIL hex2_glyph2: got %h expected 24", HEX2); end
    checks++; if (HEX1 !== 7'h30) begin errors++; $display("FAIL hex1_glyph3: got %h expected 30", HEX1); end
    checks++; if (HEX0 !== 7'h19) begin errors++; $display("FAIL hex0_glyph4: got %h expected 19", HEX0); end
    rd(16'hFFF1, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h1234) begin errors++; $display("FAIL hex_lo_read: got v=%b d=%h expected v=1 d=1234", v, d); end
    wr(16'hFFF2, 16'hFF5E);
    checks++; if (HEX5 !== 7'h12) begin errors++; $display("FAIL hex5_glyph5: got %h expected 12", HEX5); end
    checks++; if (HEX4 !== 7'h06) begin errors++; $display("FAIL hex4_glyphE: got %h expected 06", HEX4); end
    rd(16'hFFF2, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h005E) begin errors++; $display("FAIL hex_hi_read: got v=%b d=%h expected v=1 d=005e", v, d); end
  endtask

  task automatic test_ledr_decode();
    logic [15:0] d;
    logic v;
    wr(16'hFFF0, 16'hFFFF);
    checks++; if (LEDR !== 10'h3FF) begin errors++; $display("FAIL ledr_write: got %h expected 3ff", LEDR); end
    rd(16'hFFF0, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h03FF) begin errors++; $display("FAIL ledr_read: got v=%b d=%h expected v=1 d=03ff", v, d); end
    wr(16'hFFEF, 16'h0000);
    checks++; if (LEDR !== 10'h3FF) begin errors++; $display("FAIL below_base_write: got %h expected 3ff", LEDR); end
    rd(16'h1000, d, v);
    checks++; if (v !== 1'b0 || d !== 16'h0000) begin errors++; $display("FAIL below_base_read: got v=%b d=%h expected v=0 d=0000", v, d); end
    rd(16'hFFF3, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got v=%b d=%h expected v=1 d=0000", v, d); end
  endtask

  task automatic test_keys();
    logic [15:0] d1, d2, d3, d4, d5, d6;
    logic v;
    KEY = 3'b101;
    SW = 10'h2A5;
    rd(16'hFFF9, d1, v);
    rd(16'hFFF9, d2, v);
    rd(16'hFFF9, d3, v);
    rd(16'hFFFA, d4, v);
    rd(16'hFFFA, d5, v);
    KEY = 3'b111;
    rd(16'hFFF8, d6, v);
    checks++; if (d1 !== 16'h0000 || d2 !== 16'h0000) begin errors++; $display("FAIL key_sync_early: got %h,%h expected 0000,0000", d1, d2); end
    checks++; if (d3 !== 16'h0002) begin errors++; $display("FAIL key_level: got %h expected 0002", d3); end
    checks++; if (d4 !== 16'h0002) begin errors++; $display("FAIL key_latch: got %h expected 0002", d4); end
    checks++; if (d5 !== 16'h0000) begin errors++; $display("FAIL key_latch_clear: got %h expected 0000", d5); end
    checks++; if (d6 !== 16'h02A5) begin errors++; $display("FAIL sw_read: got %h expected 02a5", d6); end
  endtask

`ifdef MMIO_PERF_CNT_EN
  task automatic test_perf();
    logic [15:0] lo, hi, c1, c2, i1, ih;
    logic v;
    @(negedge Clock);
    force dut.cyc_q = 32'h0000_FFFF;
    @(posedge Clock);
    #1;
    release dut.cyc_q;
    rd(16'hFFFB, lo, v);
    rd(16'hFFFC, hi, v);
    checks++; if (lo !== 16'hFFFF || hi !== 16'h0000) begin errors++; $display("FAIL carry_pair: got hi=%h lo=%h expected hi=0000 lo=ffff", hi, lo); end
    rd(16'hFFFB, lo, v);
    rd(16'hFFFC, hi, v);
    checks++; if (hi !== 16'h0001) begin errors++; $display("FAIL post_carry_hi: got %h expected 0001", hi); end
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      InstrRetired = i[0];
    end
    @(negedge Clock);
    InstrRetired = 1'b1;
    bus.DataAddr = 16'hFFFF;
    bus.DataWr = 16'hABCD;
    bus.WriteData = 1'b1;
    @(posedge Clock);
    #1;
    bus.WriteData = 1'b0;
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", Halted); end
    rd(16'hFFFB, c1, v);
    rd(16'hFFFD, i1, v);
    rd(16'hFFFE, ih, v);
    checks++; if (c1 < 16'd100 || c1 > 16'd110) begin errors++; $display("FAIL cycle_count: got %0d expected 100..110", c1); end
    checks++; if (i1 !== 16'd51 || ih !== 16'h0000) begin errors++; $display("FAIL instr_count: got %h_%h expected 0000_0033", ih, i1); end
    repeat (20) @(posedge Clock);
    rd(16'hFFFB, c2, v);
    rd(16'hFFFD, i1, v);
    InstrRetired = 1'b0;
    checks++; if (c2 !== c1) begin errors++; $display("FAIL cycle_frozen: got %h expected %h", c2, c1); end
    checks++; if (i1 !== 16'd51) begin errors++; $display("FAIL instr_frozen: got %h expected 0033", i1); end
  endtask
`else
  task automatic test_perf();
    logic [15:0] d;
    logic v;
    rd(16'hFFFB, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL perf_absent_read: got v=%b d=%h expected v=1 d=0000", v, d); end
    wr(16'hFFFF, 16'h0000);
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", Halted); end
  endtask
`endif

  task automatic test_halted_io();
    wr(16'hFFF0, 16'h0155);
    checks++; if (LEDR !== 10'h155) begin errors++; $display("FAIL ledr_while_halted: got %h expected 155", LEDR); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", Halted); end
    do_reset();
    #1;
    checks++; if (LEDR !== 10'h000 || Halted !== 1'b0) begin errors++; $display("FAIL final_reset: got ledr=%h halted=%b expected 000/0", LEDR, Halted); end
  endtask

  initial begin
    ResetN = 1'b1;
    InstrRetired = 1'b0;
    SW = '0;
    KEY = 3'b111;
    bus.DataAddr = '0;
    bus.DataWr = '0;
    bus.WriteData = 1'b0;
    bus.ReadEn = 1'b0;
    test_reset();
    test_hex();
    test_ledr_decode();
    test_keys();
    test_perf();
    test_halted_io();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
